// File: rtl/bus_master_if.sv
// bus_master_if: requests the shared bus, then drives a burst of single-cycle beats at incrementing addresses
module bus_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] wdata,
    output logic              wdata_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              busy,
    output logic              done,
    output logic              M_req,
    input  logic              M_grant,
    output logic              M_en,
    output logic              M_wr,
    output logic [ADDR_W-1:0] M_addr,
    output logic [DATA_W-1:0] M_wdata,
    input  logic [DATA_W-1:0] M_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, XFER, REL} state_t;
    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;
    logic              r_wr;
    logic              r_req;
    logic              r_done;
    logic              r_rvalid;
    logic [DATA_W-1:0] r_rdata;
    logic              w_beat;
    logic              w_last;
    logic              w_wbeat;
    // A beat happens only while holding the bus; losing grant simply stalls the counter
    assign w_beat      = (r_state == XFER) && M_grant;
    assign w_wbeat     = w_beat && r_wr;
    assign w_last      = r_cnt == r_len - LEN_W'(1);
    assign M_req       = r_req;
    assign M_en        = w_beat;
    assign M_wr        = w_wbeat;
    assign M_addr      = w_beat ? r_addr + ADDR_W'(r_cnt) : '0;
    assign M_wdata     = w_wbeat ? wdata : '0;
    assign wdata_ack   = w_wbeat;
    assign busy        = r_state != IDLE;
    assign done        = r_done;
    assign rdata       = r_rdata;
    assign rdata_valid = r_rvalid;
    // Burst sequencer: latch the command, wait for grant, count beats, release for one cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_wr     <= 1'b0;
            r_req    <= 1'b0;
            r_done   <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_done   <= 1'b0;
            r_rvalid <= w_beat && !r_wr;
            if (w_beat && !r_wr)
                r_rdata <= M_rdata;
            case (r_state)
                IDLE: begin
                    if (start && cmd_len != '0) begin
                        r_addr  <= cmd_addr;
                        r_len   <= cmd_len;
                        r_wr    <= cmd_wr;
                        r_cnt   <= '0;
                        r_req   <= 1'b1;
                        r_state <= REQ;
                    end else if (start) begin
                        r_done <= 1'b1;
                    end
                end
                REQ: begin
                    if (M_grant)
                        r_state <= XFER;
                end
                XFER: begin
                    if (M_grant) begin
                        r_cnt <= r_cnt + LEN_W'(1);
                        if (w_last) begin
                            r_req   <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= REL;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_master_if.sv
// tb_bus_master_if: table-driven bursts against a scoreboard of expected beats and read data
module tb_bus_master_if;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          cmd_wr = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic [DW-1:0] wdata = '0;
    logic          M_grant = 1'b0;
    logic [DW-1:0] M_rdata;
    logic          wdata_ack, rdata_valid, busy, done, M_req, M_en, M_wr;
    logic [DW-1:0] rdata, M_wdata;
    logic [AW-1:0] M_addr;

    // slave model: combinational read data derived from the address
    assign M_rdata = M_addr ^ 8'hFF;

    bus_master_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wdata(wdata),
        .wdata_ack(wdata_ack), .rdata(rdata), .rdata_valid(rdata_valid),
        .busy(busy), .done(done), .M_req(M_req), .M_grant(M_grant),
        .M_en(M_en), .M_wr(M_wr), .M_addr(M_addr), .M_wdata(M_wdata),
        .M_rdata(M_rdata)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    logic [AW-1:0] q_addr[$];
    logic [DW-1:0] q_wd[$];
    logic [DW-1:0] q_rd[$];

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        int            gap_after;
        int            gap_len;
        int            mid_start;
        logic [DW-1:0] wbase;
        int            exp_done;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one burst with a grant model that answers req one cycle later,
    // optionally withholding grant for a gap, and scores every beat and read word.
    task automatic run_burst(input vec_t v);
        int   beats = 0;
        int   dones = 0;
        int   done_cyc = -1;
        int   gap_left = v.gap_len;
        int   widx = 0;
        int   cyc = 0;
        logic prev_req = 1'b0;
        for (int i = 0; i < int'(v.len); i++) begin
            q_addr.push_back(v.addr + AW'(i));
            if (v.wr) q_wd.push_back(v.wbase + DW'(i));
            else      q_rd.push_back((v.addr + AW'(i)) ^ 8'hFF);
        end
        @(negedge clk);
        start = 1'b1; cmd_wr = v.wr; cmd_addr = v.addr; cmd_len = v.len;
        while (cyc < 60 && !(done_cyc >= 0 && cyc > done_cyc + 2)) begin
            if (cyc > 0) begin
                start = (cyc == v.mid_start);
                if (start) begin cmd_addr = 8'h99; cmd_len = 4'd2; cmd_wr = !v.wr; end
            end
            if (v.gap_after > 0 && beats == v.gap_after && gap_left > 0) begin
                M_grant = 1'b0;
                gap_left--;
                check("req_in_gap", M_req, 1);
            end else begin
                M_grant = prev_req;
            end
            wdata = v.wbase + DW'(widx);
            #1;
            if (M_en) begin
                beats++;
                check("beat_wr", M_wr, v.wr);
                check("beat_ack", wdata_ack, v.wr);
                if (q_addr.size() > 0) check("beat_addr", M_addr, q_addr.pop_front());
                if (v.wr && q_wd.size() > 0) check("beat_wdata", M_wdata, q_wd.pop_front());
            end
            if (wdata_ack) widx++;
            if (rdata_valid && q_rd.size() > 0) check("rdata", rdata, q_rd.pop_front());
            else if (rdata_valid) check("rdata_valid_extra", rdata_valid, 0);
            if (done) begin
                dones++;
                done_cyc = cyc;
                check("req_at_done", M_req, 0);
            end
            prev_req = M_req;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        M_grant = 1'b0;
        check("beat_count", beats, v.len);
        check("done_count", dones, 1);
        check("done_cycle", done_cyc, v.exp_done);
        check("busy_after", busy, 0);
        check("queues_left", q_addr.size() + q_wd.size() + q_rd.size(), 0);
        q_addr.delete(); q_wd.delete(); q_rd.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //          wr  addr    len gapA gapL mid wbase  done_cycle
        tbl[0] = '{1'b1, 8'h10, 4'd4,  0, 0, 0, 8'hA0,  7};
        tbl[1] = '{1'b0, 8'h20, 4'd3,  0, 0, 0, 8'h00,  6};
        tbl[2] = '{1'b0, 8'hFE, 4'd3,  0, 0, 0, 8'h00,  6};
        tbl[3] = '{1'b1, 8'hFE, 4'd3,  0, 0, 0, 8'h30,  6};
        tbl[4] = '{1'b1, 8'h40, 4'd4,  2, 2, 0, 8'hC0,  9};
        tbl[5] = '{1'b1, 8'h50, 4'd5,  0, 0, 4, 8'h11,  8};
        tbl[6] = '{1'b0, 8'h00, 4'd15, 0, 0, 0, 8'h00, 18};

        repeat (2) @(negedge clk);
        check("reset_outputs",
              {M_req, M_en, M_wr, busy, done, rdata_valid, wdata_ack, M_addr, M_wdata, rdata}, 0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_burst(tbl[i]);

        // zero-length command: done next cycle, bus never requested
        @(negedge clk);
        start = 1'b1; cmd_len = 4'd0; cmd_wr = 1'b1; cmd_addr = 8'h33;
        #1 check("len0_req_now", M_req, 0);
        @(negedge clk);
        start = 1'b0;
        #1 check("len0_done", done, 1);
        check("len0_req", M_req, 0);
        check("len0_busy", busy, 0);
        @(negedge clk);
        #1 check("len0_done_once", done, 0);

        // reset in the middle of a burst: everything drops at once, no done
        @(negedge clk);
        start = 1'b1; cmd_wr = 1'b1; cmd_addr = 8'h70; cmd_len = 4'd8;
        @(negedge clk);
        start = 1'b0; M_grant = 1'b1;
        repeat (2) @(negedge clk);
        #1 check("pre_reset_beat", {M_en, M_req}, 2'b11);
        #1 reset_n = 1'b0;
        #1 check("async_drop", {M_req, M_en, busy, wdata_ack}, 0);
        repeat (2) begin
            @(negedge clk);
            #1 check("no_done_in_reset", {done, M_req}, 0);
        end
        @(negedge clk);
        M_grant = 1'b0;
        reset_n = 1'b1;
        run_burst(tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/bus_master_if.md
Name: bus_master_if

Overview:
Master-side requester for the two-master shared bus arbitrator. It is the other end of the arbitrator's req/grant handshake. It accepts a burst command from a local client, raises Mx_req, waits for Mx_grant, and drives LEN single-cycle beats onto the bus at incrementing addresses. It then releases the bus. One instance sits in front of each of M0 and M1 in the bus top level.

Parameters:
ADDR_W, 8, bus address width
DATA_W, 8, bus data width
LEN_W, 4, burst length field width (max burst 2^LEN_W-1 beats)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  command strobe; sampled only in IDLE
cmd_wr  input  1  1=write burst, 0=read burst
cmd_addr  input  ADDR_W  burst start address
cmd_len  input  LEN_W  beat count
wdata  input  DATA_W  client write data (first-word-fall-through)
wdata_ack  output  1  client write word consumed this cycle
rdata  output  DATA_W  read data to client
rdata_valid  output  1  rdata valid pulse
busy  output  1  state != IDLE
done  output  1  one-cycle burst-complete pulse
M_req  output  1  request to arbitrator
M_grant  input  1  grant from arbitrator
M_en  output  1  bus beat active
M_wr  output  1  bus write enable
M_addr  output  ADDR_W  bus address
M_wdata  output  DATA_W  bus write data
M_rdata  input  DATA_W  bus read data (combinational slave, same cycle)

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - All registers cleared: address, length, beat counter, mode.
  - Every output is 0. M_req drops immediately, with no wait for a clock edge.
  - A burst in progress is abandoned with no done pulse.
- States: IDLE, REQ, XFER, REL. Registered state; M_req registered.
- IDLE:
  - start=1 and cmd_len!=0: latch cmd_addr/cmd_len/cmd_wr, beat counter=0, M_req<=1, go to REQ.
  - start=1 and cmd_len=0: no request, done=1 for the next cycle, stay IDLE.
  - start is ignored in every state other than IDLE.
- REQ: M_req=1, M_en=0. On an edge with M_grant=1, go to XFER.
- XFER: M_req=1. A beat occurs in every cycle with M_grant=1.
  - During a beat (combinational): M_en=1, M_wr=latched mode, M_addr=base+beat_cnt mod 2^ADDR_W, M_wdata=wdata (write only).
  - wdata_ack=M_en&M_wr. The client must present the next word after each ack.
  - Read beat: M_rdata is registered to rdata, and rdata_valid=1 in the following cycle.
  - Beat counter increments on each beat edge.
- Grant loss mid-burst: if M_grant=0 in XFER, M_en=0, wdata_ack=0, and the counter holds. The master stays in XFER with M_req=1 and resumes when grant returns. No beat is lost or duplicated.
- Last beat (beat_cnt=len-1 with grant): go to REL.
- REL: M_req=0, M_en=0, done=1, busy=1. Unconditionally go to IDLE on the next edge.
- Cadence: minimum one idle cycle between bursts. With a one-cycle grant latency, start→done takes len+3 cycles.
- The block does not check the address against the slave map; address wrap-around is silent.

Test Plan:
1. Write burst: reset, then start with cmd_wr=1, addr=0x10, len=4, wdata from an incrementing client source 0xA0..; arbitrator grants one cycle after req -> M_req rises the cycle after start; M_en high for exactly 4 cycles with M_addr=0x10,0x11,0x12,0x13 and M_wdata=0xA0..0xA3; 4 wdata_ack pulses; done pulses 1 cycle later while M_req=0.
2. Read burst: cmd_wr=0, addr=0x20, len=3, slave returns M_rdata=addr^0xFF -> rdata_valid three pulses, each one cycle after its beat, rdata=0xDF,0xDE,0xDD; M_wr=0 throughout.
3. Address wrap: addr=0xFE, len=3 -> M_addr=0xFE,0xFF,0x00.
4. Grant gap: len=4 with grant dropped for 2 cycles after beat 2 -> M_en low for those 2 cycles while M_req stays high; exactly 4 beats total at consecutive addresses; done asserted once.
5. Two instances with the real arbitrator, both started in the same cycle -> bursts are serialized and never have M_en high together; each instance gives one done.
6. Edge cases: len=0 -> done pulse with no M_req. start asserted during XFER -> ignored. reset_n=0 mid-XFER -> M_req/M_en drop asynchronously, no done, and the next start works normally.
